tlc_lamp_monitor: RTL

Lamp-side monitor for the two-road traffic-light controller. It samples the six lamp drives (GRN1, YLW1, RED1, GRN2, YLW2, RED2) and decodes each road's phase. It checks lamp encoding, mutual-exclusion safety, phase ordering and minimum yellow time, and reports how long each combined phase lasted. It sits on the receiving end of the controller's lamp outputs, in the test harness or in silicon as an on-line safety checker.

---
 rtl/tlc_lamp_monitor.sv | 133 +++++++++++++
 1 files changed

// File: rtl/tlc_lamp_monitor.sv
// Lamp-side safety monitor for a two-road traffic-light controller: decodes each road's phase,
// flags encoding/safety/ordering/short-yellow faults and reports combined-phase dwell times.
module tlc_lamp_monitor #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned YLW_MIN = 2
) (
  input  logic             CK,
  input  logic             CLR,
  input  logic             GRN1,
  input  logic             YLW1,
  input  logic             RED1,
  input  logic             GRN2,
  input  logic             YLW2,
  input  logic             RED2,
  output logic [1:0]       PH1,
  output logic [1:0]       PH2,
  output logic             CHG,
  output logic [CNT_W-1:0] DWELL,
  output logic             ERR_LAMP,
  output logic             ERR_SAFE,
  output logic             ERR_SEQ,
  output logic             ERR_YLW,
  output logic [7:0]       ERR_CNT
);

  localparam logic [1:0]       PhInv  = 2'b00;
  localparam logic [1:0]       PhGrn  = 2'b01;
  localparam logic [1:0]       PhYlw  = 2'b10;
  localparam logic [1:0]       PhRed  = 2'b11;
  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] YlwMin = CNT_W'(YLW_MIN);

  function automatic logic [1:0] decode(input logic [2:0] gyr);
    case (gyr)
      3'b100:  return PhGrn;
      3'b010:  return PhYlw;
      3'b001:  return PhRed;
      default: return PhInv;
    endcase
  endfunction

  function automatic logic legal_step(input logic [1:0] from, input logic [1:0] to);
    return (to == from) || (from == PhGrn && to == PhYlw) ||
           (from == PhYlw && to == PhRed) || (from == PhRed && to == PhGrn);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CntMax) ? v : v + CntOne;
  endfunction

  // Stage 1: raw lamp capture; vld_q marks that lamp_q holds a real sample since reset.
  logic [5:0]            lamp_q;
  logic                  vld_q;
  logic [1:0][2:0]       road_lamps;

  // Stage 2 state: index 0 is road 1, index 1 is road 2.
  logic [1:0][1:0]       ph_q, ph_d;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]      comb_cnt_q, comb_cnt_d;
  logic [CNT_W-1:0]      dwell_q, dwell_d;
  logic                  chg_q, chg_d;
  logic                  err_lamp_q, err_safe_q, err_seq_q, err_ylw_q;
  logic [7:0]            err_cnt_q, err_cnt_d;
  logic                  ev_lamp, ev_safe, ev_seq, ev_ylw, ev_any;

  assign road_lamps = {lamp_q[2:0], lamp_q[5:3]};

  always_comb begin
    ph_d    = '0;
    cnt_d   = '0;
    ev_lamp = 1'b0;
    ev_seq  = 1'b0;
    ev_ylw  = 1'b0;
    for (int r = 0; r < 2; r++) begin
      ph_d[r] = vld_q ? decode(road_lamps[r]) : PhInv;
      if (vld_q && ph_d[r] == PhInv) ev_lamp = 1'b1;
      // A road is armed once its registered phase is valid; 00 on either side is never checked.
      if (ph_q[r] != PhInv && ph_d[r] != PhInv && !legal_step(ph_q[r], ph_d[r])) ev_seq = 1'b1;
      if (ph_q[r] == PhYlw && ph_d[r] == PhRed && cnt_q[r] < YlwMin) ev_ylw = 1'b1;
      cnt_d[r] = (ph_d[r] != ph_q[r]) ? CntOne : sat_inc(cnt_q[r]);
    end
    ev_safe = (ph_d[0] != PhInv) && (ph_d[1] != PhInv) &&
              (ph_d[0] != PhRed) && (ph_d[1] != PhRed);
    ev_any  = ev_lamp | ev_safe | ev_seq | ev_ylw;

    chg_d      = (ph_d != ph_q);
    comb_cnt_d = chg_d ? CntOne : sat_inc(comb_cnt_q);
    dwell_d    = chg_d ? comb_cnt_q : dwell_q;
    err_cnt_d  = (ev_any && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  always_ff @(posedge CK) begin
    if (CLR) begin
      lamp_q     <= '0;
      vld_q      <= 1'b0;
      ph_q       <= '0;
      cnt_q      <= '0;
      comb_cnt_q <= '0;
      dwell_q    <= '0;
      chg_q      <= 1'b0;
      err_lamp_q <= 1'b0;
      err_safe_q <= 1'b0;
      err_seq_q  <= 1'b0;
      err_ylw_q  <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      lamp_q     <= {GRN1, YLW1, RED1, GRN2, YLW2, RED2};
      vld_q      <= 1'b1;
      ph_q       <= ph_d;
      cnt_q      <= cnt_d;
      comb_cnt_q <= comb_cnt_d;
      dwell_q    <= dwell_d;
      chg_q      <= chg_d;
      err_lamp_q <= err_lamp_q | ev_lamp;
      err_safe_q <= err_safe_q | ev_safe;
      err_seq_q  <= err_seq_q | ev_seq;
      err_ylw_q  <= err_ylw_q | ev_ylw;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign PH1      = ph_q[0];
  assign PH2      = ph_q[1];
  assign CHG      = chg_q;
  assign DWELL    = dwell_q;
  assign ERR_LAMP = err_lamp_q;
  assign ERR_SAFE = err_safe_q;
  assign ERR_SEQ  = err_seq_q;
  assign ERR_YLW  = err_ylw_q;
  assign ERR_CNT  = err_cnt_q;

endmodule
